// File: rtl/conv_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_output_serializer
// Brief    : Double-buffered row-to-word serializer for the convolution
//            kernel array result bus. Each accepted bus is one output row,
//            emitted lane 0 first with a feature-map address.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_output_serializer #(
   parameter int WIDTH       = 32,
   parameter int ARRAY_SIZE  = 6,
   parameter int IMAGE_SIZE  = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_valid,
   input  logic [ARRAY_SIZE*WIDTH-1:0] i_pixel_bus,
   output logic                        o_ready,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [WIDTH-1:0]            o_feature,
   output logic [ADDR_WIDTH-1:0]       o_addr,
   output logic                        o_last,
   output logic                        o_frame_done
);

   localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
   localparam int LANE_W   = $clog2(ARRAY_SIZE > 1 ? ARRAY_SIZE : 2);
   localparam int ROW_W    = $clog2(OUT_SIZE > 1 ? OUT_SIZE : 2);
   localparam logic [LANE_W-1:0] C_LANE_LAST = LANE_W'(ARRAY_SIZE - 1);
   localparam logic [ROW_W-1:0]  C_ROW_LAST  = ROW_W'(OUT_SIZE - 1);

   // Occupancy of the ping/pong buffers doubles as the FSM state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                      state_q;
   logic [ARRAY_SIZE*WIDTH-1:0] buf_q [2];
   logic                        wr_ptr_q;
   logic                        rd_ptr_q;
   logic [LANE_W-1:0]           lane_cnt_q;
   logic [ROW_W-1:0]            row_cnt_q;
   logic                        frame_done_q;

   logic                        accept_w;
   logic                        pop_w;
   logic                        row_end_w;
   logic [ARRAY_SIZE*WIDTH-1:0] rd_row_w;
   logic [LANE_W-1:0]           lane_cnt_d;
   logic [ROW_W-1:0]            row_cnt_d;

   // Handshakes and next-value counters; o_ready depends on state only.
   always_comb begin
      accept_w   = i_valid && (state_q != ST_FULL);
      pop_w      = (state_q != ST_EMPTY) && i_ready;
      row_end_w  = pop_w && (lane_cnt_q == C_LANE_LAST);
      lane_cnt_d = lane_cnt_q;
      row_cnt_d  = row_cnt_q;
      if (pop_w) begin
         if (lane_cnt_q == C_LANE_LAST) begin
            lane_cnt_d = '0;
            row_cnt_d  = (row_cnt_q == C_ROW_LAST) ? '0 : row_cnt_q + 1'b1;
         end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
         end
      end
   end

   // Buffer capture, pointer/counter update and occupancy state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         buf_q[0]     <= '0;
         buf_q[1]     <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         lane_cnt_q   <= '0;
         row_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (accept_w) begin
            buf_q[wr_ptr_q] <= i_pixel_bus;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (row_end_w) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         lane_cnt_q   <= lane_cnt_d;
         row_cnt_q    <= row_cnt_d;
         frame_done_q <= pop_w && o_last;
         case (state_q)
            ST_EMPTY: if (accept_w) state_q <= ST_ONE;
            ST_ONE: begin
               if (accept_w && !row_end_w)      state_q <= ST_FULL;
               else if (!accept_w && row_end_w) state_q <= ST_EMPTY;
            end
            ST_FULL:  if (row_end_w) state_q <= ST_ONE;
            default:  state_q <= ST_EMPTY;
         endcase
      end
   end

   // Output word selection straight from the registered read-side state.
   always_comb begin
      rd_row_w     = buf_q[rd_ptr_q];
      o_ready      = (state_q != ST_FULL);
      o_valid      = (state_q != ST_EMPTY);
      o_feature    = rd_row_w[lane_cnt_q*WIDTH +: WIDTH];
      o_addr       = ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(ARRAY_SIZE)
                   + ADDR_WIDTH'(lane_cnt_q);
      o_last       = o_valid && (row_cnt_q == C_ROW_LAST)
                   && (lane_cnt_q == C_LANE_LAST);
      o_frame_done = frame_done_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_output_serializer
// Brief    : Scoreboard bench: the stimulus pushes expected words, a monitor
//            pops and compares each transferred word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_output_serializer;

   localparam int W  = 32;
   localparam int AS = 6;
   localparam int OS = 6;
   localparam int AW = 6;

   typedef struct packed {
      logic [W-1:0]  f;
      logic [AW-1:0] a;
      logic          l;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_valid = 1'b0;
   logic [AS*W-1:0] i_pixel_bus = '0;
   logic            o_ready;
   logic            o_valid;
   logic            i_ready = 1'b1;
   logic [W-1:0]    o_feature;
   logic [AW-1:0]   o_addr;
   logic            o_last;
   logic            o_frame_done;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   int   exp_row = 0;
   int   n_pop   = 0;
   bit   bp_en   = 1'b0;
   bit   stall   = 1'b0;

   conv_layer_output_serializer #(
      .WIDTH(W), .ARRAY_SIZE(AS), .IMAGE_SIZE(8), .KERNEL_SIZE(3), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_pixel_bus(i_pixel_bus),
      .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
      .o_feature(o_feature), .o_addr(o_addr), .o_last(o_last),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   // Downstream ready: backpressure pattern 1,0,0,1 repeating when enabled.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (stall)      i_ready = 1'b0;
         else if (bp_en) i_ready = (ph == 0) || (ph == 3);
         else            i_ready = 1'b1;
         ph = (ph + 1) % 4;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: compare words as they transfer, check hold and frame_done.
   initial begin
      exp_t e;
      exp_t held;
      bit   held_v = 1'b0;
      bit   fd_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
            fd_exp = 1'b0;
         end else begin
            chk("frame_done", 64'(o_frame_done), 64'(fd_exp));
            if (held_v && o_valid)
               chk("held_word", {o_feature, o_addr, o_last}, 64'(held));
            held_v = 1'b0;
            fd_exp = 1'b0;
            if (o_valid && i_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got addr %0d data %0h, expected none",
                           o_addr, o_feature);
               end else begin
                  e = sb.pop_front();
                  chk("word", {o_feature, o_addr, o_last}, 64'(e));
                  fd_exp = e.l;
               end
               n_pop++;
            end else if (o_valid) begin
               held   = '{o_feature, o_addr, o_last};
               held_v = 1'b1;
            end
         end
      end
   end

   function automatic logic [W-1:0] val(input int tag, input int k);
      return (tag == 0) ? W'(32'h11 * (k + 1)) : W'(32'hA000_0000 + (tag << 8) + k);
   endfunction

   // Present one bus, hold until accepted, then record its six words.
   task automatic send(input int tag);
      bit rdy;
      int budget = 0;
      for (int k = 0; k < AS; k++) i_pixel_bus[k*W +: W] = val(tag, k);
      i_valid = 1'b1;
      forever begin
         rdy = o_ready;
         @(posedge clk);
         if (rdy) break;
         budget++;
         if (budget > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0, expected 1 within 200 cycles");
            break;
         end
      end
      if (rdy) begin
         for (int k = 0; k < AS; k++)
            sb.push_back('{val(tag, k), AW'(exp_row * AS + k),
                           (exp_row == OS - 1) && (k == AS - 1)});
         exp_row = (exp_row + 1) % OS;
      end
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while ((sb.size() != 0 || o_valid) && budget < 300) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int brow;
      int target;
      int budget;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      // Reset state
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_addr", 64'(o_addr), 64'(0));
      chk("rst_feature", 64'(o_feature), 64'(0));
      chk("rst_last", 64'(o_last), 64'(0));

      // Single bus: first word visible the cycle after accept
      send(0);
      chk("lat_valid", 64'(o_valid), 64'(1));
      chk("lat_addr", 64'(o_addr), 64'(0));
      chk("lat_feature", 64'(o_feature), 64'(32'h11));
      drain();

      // Three back-to-back buses: ready drops after the second accept
      send(1);
      send(2);
      chk("full_ready", 64'(o_ready), 64'(0));
      send(3);
      drain();

      // Backpressure over rows 4 and 5, closing the frame at addr 35
      bp_en = 1'b1;
      send(4);
      send(5);
      drain();
      bp_en = 1'b0;

      // Next frame restarts at 0; accept coincides with final-lane pop
      send(6);
      budget = 0;
      while (!(o_valid && o_addr == AW'(5)) && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      chk("lane5_reached", 64'(o_addr), 64'(5));
      brow = exp_row;
      send(7);
      chk("nogap_valid", 64'(o_valid), 64'(1));
      chk("nogap_ready", 64'(o_ready), 64'(1));
      chk("nogap_addr", 64'(o_addr), 64'(brow * AS));
      drain();

      // Reset after three words of the row at row index 2
      target = n_pop + 3;
      send(8);
      budget = 0;
      while (n_pop < target && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      rst   = 1'b1;
      stall = 1'b1;
      sb.delete();
      exp_row = 0;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 64'(o_valid), 64'(0));
      chk("mid_rst_ready", 64'(o_ready), 64'(1));
      chk("mid_rst_addr", 64'(o_addr), 64'(0));
      rst   = 1'b0;
      stall = 1'b0;
      @(posedge clk);
      #1;
      send(9);
      chk("restart_addr", 64'(o_addr), 64'(0));
      drain();
      chk("pop_total", 64'(n_pop), 64'(6 * 8 + 3 + 6));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
